// File: rtl/bin_mem_pkg.sv
// bin_mem_pkg: shared FSM encoding and default geometry for the binary cell array controller
package bin_mem_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;
endpackage

// File: rtl/bin_mem_if.sv
// bin_mem_if: request/response handshake plus array-side pins of the cell array controller
interface bin_mem_if
  import bin_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int DEPTH = 1 << ADDR_W;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [DEPTH-1:0]  cs;
  logic              r;
  logic              w;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;
  modport master (
    output req_valid, req_wr, req_addr, req_data, q,
    input  req_ready, rsp_valid, rsp_data, cs, r, w, d
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_data, q,
    output req_ready, rsp_valid, rsp_data, cs, r, w, d
  );
endinterface

// File: rtl/cs_decoder.sv
// cs_decoder: row address to one-hot chip select, all-zero when disabled
module cs_decoder #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [DEPTH-1:0]  sel
);
  assign sel = en ? DEPTH'(1) << addr : '0;
endmodule

// File: rtl/bin_mem_ctrl.sv
// bin_mem_ctrl: sequences single-word read/write requests onto a row-organised cell array
module bin_mem_ctrl
  import bin_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic     clk,
  input logic     rst,
  bin_mem_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  state_t            state, state_nx;
  logic              accept, busy_nx, wr_q, wr_sel;
  logic [ADDR_W-1:0] addr_q, addr_sel;
  logic [DATA_W-1:0] data_q, data_sel, d_nx;
  logic [DEPTH-1:0]  cs_nx;
  logic              r_nx, w_nx, rsp_valid_nx;
  assign accept        = state == IDLE && bus.req_valid;
  assign bus.req_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE   ? (bus.req_valid ? SETUP : IDLE) :
               state == SETUP  ? STROBE :
               state == STROBE ? HOLD : IDLE;
  // Array pins are registered, so on the accept edge the fresh request feeds them directly
  always_comb begin
    wr_sel       = accept ? bus.req_wr   : wr_q;
    addr_sel     = accept ? bus.req_addr : addr_q;
    data_sel     = accept ? bus.req_data : data_q;
    busy_nx      = state_nx != IDLE;
    d_nx         = busy_nx && wr_sel ? data_sel : '0;
    w_nx         = state_nx == STROBE && wr_q;
    r_nx         = state_nx == STROBE && !wr_q;
    rsp_valid_nx = state_nx == HOLD && !wr_q;
  end
  cs_decoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec (
    .addr(addr_sel),
    .en  (busy_nx),
    .sel (cs_nx)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      wr_q   <= bus.req_wr;
      addr_q <= bus.req_addr;
      data_q <= bus.req_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.cs        <= '0;
      bus.r         <= 1'b0;
      bus.w         <= 1'b0;
      bus.d         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.cs        <= cs_nx;
      bus.r         <= r_nx;
      bus.w         <= w_nx;
      bus.d         <= d_nx;
      bus.rsp_valid <= rsp_valid_nx;
      if (state == STROBE && !wr_q) bus.rsp_data <= bus.q;
    end
endmodule

// File: tb/tb_bin_mem_ctrl.sv
// tb_bin_mem_ctrl: drives requests against a cell array model and scoreboards read responses
module tb_bin_mem_ctrl;
  import bin_mem_pkg::*;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 1 << AW;
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bin_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  bin_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (bus.cs[i] && bus.w) mem[i] <= bus.d;
  always_comb begin
    bus.q = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.cs[i]) bus.q = bus.q | mem[i];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    chk("cs_shape", $countones(bus.cs), bus.req_ready ? 0 : 1);
    chk("rw_excl", 32'(bus.r & bus.w), 0);
    if (bus.rsp_valid) begin
      if (sb.size() == 0) chk("rsp_spurious", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_lat", cyc, e.due);
      end
    end
  end
  // Call at a negedge; returns at the HOLD negedge with acc = cycle index of the SETUP negedge
  task automatic op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                    input logic keep, output int acc);
    logic [DEPTH-1:0] cs_s[3];
    logic [DW-1:0]    d_s[3];
    logic [2:0]       w_s, r_s;
    logic [DW-1:0]    rsp0;
    int               n;
    bus.req_wr = wr;
    bus.req_addr = a;
    bus.req_data = dt;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 0, 1);
    rsp0 = bus.rsp_data;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (!keep) bus.req_valid = 1'b0;
    if (wr) ref_mem[a] = dt;
    else sb.push_back('{ref_mem[a], acc + 2});
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      cs_s[k] = bus.cs;
      d_s[k] = bus.d;
      w_s[k] = bus.w;
      r_s[k] = bus.r;
      chk("ready_busy", 32'(bus.req_ready), 0);
      if (k < 2) begin
        bus.req_addr = AW'($urandom);
        bus.req_data = DW'($urandom);
        bus.req_wr = 1'($urandom);
      end
    end
    chk("w_seq", 32'(w_s), wr ? 3'b010 : 3'b000);
    chk("r_seq", 32'(r_s), wr ? 3'b000 : 3'b010);
    for (int k = 0; k < 3; k++) begin
      chk("cs_hold", 32'(cs_s[k]), 32'(DEPTH'(1) << a));
      chk("d_hold", 32'(d_s[k]), wr ? 32'(dt) : 0);
    end
    if (wr) chk("wr_rsp_keep", 32'(bus.rsp_data), 32'(rsp0));
  endtask
  initial begin
    int a0, a1, a2, n;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", {bus.cs, bus.r, bus.w, bus.d, bus.rsp_valid, bus.rsp_data}, 0);
    chk("rst_ready", 32'(bus.req_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    op(1'b1, 4'd3, 4'h6, 1'b0, a0);
    @(negedge clk);
    bus.req_wr = 1'b1;
    bus.req_addr = 4'd3;
    bus.req_data = 4'h9;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("setup_cs", 32'(bus.cs), 32'h8);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("abort_cs", 32'(bus.cs), 0);
    chk("abort_w", 32'(bus.w), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("ready_after_rst", 32'(bus.req_ready), 1);
    op(1'b0, 4'd3, 4'h0, 1'b0, a0);
    op(1'b1, 4'd5, 4'hA, 1'b0, a0);
    op(1'b0, 4'd5, 4'h0, 1'b0, a0);
    op(1'b1, 4'd7, 4'h3, 1'b0, a0);
    for (int i = 0; i < DEPTH; i++) op(1'b1, AW'(i), DW'(i) ^ 4'h5, 1'b0, a0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, AW'(i), 4'h0, 1'b0, a0);
    op(1'b0, 4'd1, 4'h0, 1'b1, a0);
    op(1'b0, 4'd2, 4'h0, 1'b1, a1);
    op(1'b0, 4'd3, 4'h0, 1'b0, a2);
    chk("b2b_gap1", a1 - a0, 4);
    chk("b2b_gap2", a2 - a1, 4);
    @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      chk("idle_quiet", {bus.cs, bus.r, bus.w, bus.rsp_valid}, 0);
    end
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin_mem_ctrl.md
# bin_mem_ctrl

Controller that sits on the initiator side of a row-organised array of binary storage cells, each cell exposing D, R, W, CS, CLK and a read output O. It accepts single-word read/write requests over a valid/ready handshake and sequences them onto the array as one-hot chip select plus read/write strobes with setup and hold phases. It captures read data from the array's read bus and returns it with a response strobe. One request is in flight at a time.

## Interface
- ADDR_W, 4, row address width; DEPTH = 2**ADDR_W rows
- DATA_W, 4, bits per row (cells per row)
- CLK  in  1  system clock, also driven to the array's cell CLK inputs
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  controller can accept a request
- REQ_WR  in  1  1 = write, 0 = read
- REQ_ADDR  in  ADDR_W  row address
- REQ_DATA  in  DATA_W  write data
- RSP_VALID  out  1  one-cycle pulse: read data valid on RSP_DATA
- RSP_DATA  out  DATA_W  captured read word
- CS  out  DEPTH  one-hot row select to the array
- R  out  1  read strobe, shared by all rows
- W  out  1  write strobe, shared by all rows
- D  out  DATA_W  write data bus to the array
- Q  in  DATA_W  read bus from the array (selected row's O outputs)

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: REQ_READY=1, CS=0, R=W=0. On a clock edge with REQ_VALID=1, latch REQ_WR, REQ_ADDR and REQ_DATA, then go to SETUP. REQ_VALID=0 keeps the FSM in IDLE.
- SETUP: CS=onehot(addr). D=latched data on a write and 0 on a read. R=W=0. Go to STROBE.
- STROBE: CS and D held. W=1 on a write, R=1 on a read. On a read, Q is registered into RSP_DATA at the edge that leaves STROBE. Go to HOLD.
- HOLD: CS and D held, R=W=0. RSP_VALID=1 for this cycle on a read only. Go to IDLE.
- All array-side outputs and RSP_* are registered; no combinational path from REQ_* to the array pins.
- Writes never change RSP_DATA; it retains the last read value.
- Q bits that are X/Z are captured as-is. No X-scrubbing.
- REQ_VALID and all request fields are ignored outside IDLE. No queuing and no error flag.

## Timing
- Accept edge N (IDLE with REQ_VALID=1). Then SETUP is cycle N+1, STROBE N+2, HOLD N+3, and IDLE again at N+4.
- Throughput: one operation per 4 cycles. Back-to-back requests give CS a 1-cycle low gap between operations.
- Read latency: RSP_VALID high in cycle N+3, with RSP_DATA = Q as sampled at the end of cycle N+2.
- Write: the array captures D at the edge ending the STROBE cycle. D and CS are stable one cycle before and one cycle after W.
- R and W are never high in the same cycle. CS is never multi-hot.
- Reset values, applied immediately on RST rise: state=IDLE, CS=0, R=0, W=0, D=0, RSP_VALID=0, RSP_DATA=0. REQ_READY=1 while the state is IDLE, but requests are not accepted while RST=1.
- RST mid-operation aborts the operation at once: strobes drop asynchronously and no RSP_VALID is produced. A write aborted before its STROBE edge leaves the row unmodified.
- Address wrap does not arise: DEPTH = 2**ADDR_W, so every address decodes.

## Structure
- Shared package/include bin_mem_pkg holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3);
  - the default ADDR_W and DATA_W.
- Sub-module cs_decoder (ADDR_W in, DEPTH one-hot out, plus enable) generates CS. Its output is registered in bin_mem_ctrl.
- The FSM, request latches and RSP_DATA register live in bin_mem_ctrl.
- The bench instantiates a DEPTH×DATA_W array of cells and connects them as follows:
  - CS[i] to every cell of row i;
  - R, W and D to every row;
  - Q as the bitwise OR of the rows' O outputs, with unselected rows masked to 0.

## Test plan
- Reset: assert RST mid-SETUP of a write to addr 3 → CS=0, W=0 immediately. After release, a read of addr 3 returns the prior content; REQ_READY=1.
- Write then read: write 4'hA to addr 5, then read addr 5 → RSP_VALID pulses exactly 3 cycles after the read's accept edge, with RSP_DATA=4'hA.
- Sweep: write addr i ← i^4'h5 for all 16 addresses, then read all → every read matches. CS is one-hot in every SETUP/STROBE/HOLD cycle.
- Back-to-back: hold REQ_VALID=1 for 3 reads → accepts occur every 4 cycles. REQ_READY=0 in the 3 cycles between accepts; request-field changes there are ignored.
- Strobe checks: on a write, W is high for exactly 1 cycle, with D and CS constant from SETUP through HOLD. R and W are never both 1. A write leaves RSP_DATA unchanged (e.g. stays 4'hA).
- Idle stability: REQ_VALID=0 for 20 cycles → CS, R and W stay 0 and RSP_VALID never pulses.
